// File: rtl/dmem_access_controller.sv
// dmem_access_controller
//   Runs each MEM-stage load or store on a handshaked, variable-latency
//   data-memory port. It freezes the pipeline until the access completes,
//   and it aborts the access with a sticky bus error if the memory never
//   acknowledges.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   MemRead, MemWrite   load / store request from EX/MEM (store wins if both)
//   Address, WriteData  effective address and store data
//   mem_ack, mem_rdata  memory completion strobe and load data
//   mem_req, mem_we     registered request and direction (1 = store)
//   mem_addr, mem_wdata registered address and store data
//   ReadData            captured load data for MEM/WB
//   stall               combinational freeze request
//   access_done         one-cycle completion pulse
//   bus_error           sticky timeout flag
//
// Handshake: mem_req rises together with stable mem_addr/mem_we/mem_wdata.
// All of them hold until a cycle in which mem_ack=1 is sampled; that cycle
// completes the transfer. mem_ack is ignored whenever mem_req=0.
module dmem_access_controller #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] ReadData,
  output logic              stall,
  output logic              access_done,
  output logic              bus_error
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Value of the counter in the last ACCESS cycle that is allowed to wait.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (MemRead || MemWrite) begin
          addr_d  = Address;
          wdata_d = WriteData;
          we_d    = MemWrite;   // store takes priority over load
          req_d   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // A late ack on the expiry cycle still counts as a success.
        if (mem_ack) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d = 1'b0;
          err_d = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // The request inputs here still belong to the completing instruction.
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign ReadData    = rdata_q;
  assign bus_error   = err_q;
  assign access_done = (state_q == ST_DONE);
  // Gate stall with rst_n so the pipeline is never frozen while in reset.
  assign stall = rst_n &&
                 (((state_q == ST_IDLE) && (MemRead || MemWrite)) ||
                  (state_q == ST_ACCESS));

endmodule

// File: doc/dmem_access_controller.md
Name: dmem_access_controller

Overview:
- Sequences every load/store in the MEM stage onto a handshaked, variable-latency data-memory port.
- Freezes the pipeline with a stall output until the access completes. This stall is ORed into the stall input of the control unit and into the pipeline-register enables.
- Enforces a timeout so that a memory which never acknowledges cannot hang the core.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- TIMEOUT, 15, maximum cycles in ACCESS without mem_ack before abort; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- MemRead  input  1  load request from the EX/MEM register.
- MemWrite  input  1  store request from the EX/MEM register.
- Address  input  ADDR_W  effective address from the ALU.
- WriteData  input  DATA_W  store data.
- mem_ack  input  1  memory completion; meaningful only while mem_req=1.
- mem_rdata  input  DATA_W  read data; valid in the cycle mem_ack=1.
- mem_req  output  1  registered request to memory.
- mem_we  output  1  registered; 1 = store, 0 = load.
- mem_addr  output  ADDR_W  registered address.
- mem_wdata  output  DATA_W  registered store data.
- ReadData  output  DATA_W  captured load data, fed to the MEM/WB register.
- stall  output  1  freeze-pipeline request.
- access_done  output  1  one-cycle completion pulse.
- bus_error  output  1  sticky timeout flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; counter is cleared.
  - mem_req, mem_we, mem_addr, mem_wdata, ReadData, access_done and bus_error are all 0.
  - stall is forced to 0 while rst_n=0.
  - Reset asserted mid-access drops mem_req immediately; the aborted access is not retried.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If MemRead|MemWrite, latch Address, WriteData and we=MemWrite into the mem_* registers, set mem_req=1 and go to ACCESS.
  - If both MemRead and MemWrite are 1, the store wins.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_req is held at 1 and mem_addr/mem_we/mem_wdata are held stable.
  - Counter increments each cycle.
  - mem_ack=1: clear mem_req, capture mem_rdata into ReadData only if mem_we=0, go to DONE.
  - No ack and counter==TIMEOUT-1: clear mem_req, set bus_error=1, load ReadData=0 if it was a load, go to DONE.
  - An ack arriving in the same cycle as timeout expiry counts as a success: no error.
- DONE:
  - access_done=1 for exactly this cycle; counter is cleared.
  - MemRead/MemWrite are ignored, because they still belong to the completing instruction.
  - Always go to IDLE next cycle.
- stall (combinational): 1 when (state==IDLE and (MemRead|MemWrite)) or state==ACCESS; 0 in DONE. The completing instruction advances at the end of the DONE cycle.
- Latency:
  - Request first seen in cycle 0 (IDLE); mem_req is high from cycle 1.
  - Ack in cycle k (k≥1) gives DONE in cycle k+1 and stall high for cycles 0..k.
  - Minimum: ack in cycle 1 gives 2 stall cycles.
- Back-to-back accesses: the next instruction's request is first evaluated in the IDLE cycle after DONE. No request is lost.
- Ignored conditions: mem_ack while mem_req=0; changes on MemRead/MemWrite/Address/WriteData during ACCESS (the latched copies are used).
- ReadData holds its value until the next completed load, a timeout on a load, or reset.
- bus_error stays at 1 until reset.
- Counter width is 8 bits; it never wraps, because it is bounded by TIMEOUT.

Test Plan:
- Reset release with MemRead=0 -> all outputs 0, state IDLE; MemRead=1 during rst_n=0 -> stall=0.
- Load, Address=0x100, mem_ack at the 3rd mem_req cycle with mem_rdata=0xDEADBEEF -> stall high 4 cycles; mem_addr=0x100 and mem_we=0 stable while requested; access_done pulses once; ReadData=0xDEADBEEF.
- Store, Address=0x200, WriteData=0x55 with MemRead=MemWrite=1, ack in 1st cycle -> mem_we=1, mem_wdata=0x55; stall high 2 cycles; ReadData unchanged.
- Load with no ack, TIMEOUT=15 -> mem_req drops after 15 cycles; bus_error=1 and stays set; ReadData=0; a following load with ack completes normally and bus_error remains 1.
- Two consecutive loads (MemRead kept high through DONE, then a new Address=0x300) -> exactly two mem_req bursts; no request issued during DONE.
- rst_n pulsed low during ACCESS -> mem_req=0 asynchronously; after release, IDLE, no spurious access_done.
